// File: rtl/mips_defs.sv
// Shared encodings for the multicycle MIPS controller: opcodes, functs,
// datapath select codes, FSM state encoding and the decode-stage lookup.
package mips_defs;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_SLLV = 6'h04;
   localparam logic [5:0] FN_SRLV = 6'h06;
   localparam logic [5:0] FN_SRAV = 6'h07;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_SLT  = 6'h2A;

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_SLT = 4'd4;
   localparam logic [3:0] ALU_LUI = 4'd5;

   localparam logic [1:0] NPC_PC4    = 2'd0;
   localparam logic [1:0] NPC_BRANCH = 2'd1;
   localparam logic [1:0] NPC_JUMP   = 2'd2;
   localparam logic [1:0] NPC_JR     = 2'd3;

   localparam logic [1:0] RD_RT = 2'd0;
   localparam logic [1:0] RD_RD = 2'd1;
   localparam logic [1:0] RD_RA = 2'd2;

   localparam logic [1:0] M2R_ALU = 2'd0;
   localparam logic [1:0] M2R_DM  = 2'd1;
   localparam logic [1:0] M2R_PC4 = 2'd2;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_EXEC_R = 4'd2,
      S_EXEC_I = 4'd3,
      S_ADDR   = 4'd4,
      S_MEM_RD = 4'd5,
      S_MEM_WR = 4'd6,
      S_WB_ALU = 4'd7,
      S_WB_MEM = 4'd8,
      S_BRANCH = 4'd9,
      S_JUMP   = 4'd10,
      S_ERR    = 4'd11
   } state_t;

   function automatic logic r_funct_ok(input logic [5:0] funct);
      return funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLL,
                           FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV};
   endfunction

   // Where S_DECODE goes; unknown opcodes and R-type functs trap to S_ERR.
   function automatic state_t decode_next(input logic [5:0] op, input logic [5:0] funct);
      state_t nxt;
      case (op)
         OP_RTYPE: begin
            if (funct == FN_JR)        nxt = S_JUMP;
            else if (r_funct_ok(funct)) nxt = S_EXEC_R;
            else                        nxt = S_ERR;
         end
         OP_ADDI, OP_ORI, OP_LUI: nxt = S_EXEC_I;
         OP_LW, OP_SW:            nxt = S_ADDR;
         OP_BEQ, OP_BNE:          nxt = S_BRANCH;
         OP_J, OP_JAL:            nxt = S_JUMP;
         default:                 nxt = S_ERR;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational ALU/shifter control from the latched op/funct; used while
// executing and writing back ALU-class instructions.
import mips_defs::*;

module alu_decode (
   input  logic [5:0] op,
   input  logic [5:0] funct,
   output logic [3:0] alu_op,
   output logic       alu_asrc,
   output logic       shift_index,
   output logic       shift_dir,
   output logic       s_arith
);

   always_comb begin
      alu_op      = ALU_ADD;
      alu_asrc    = 1'b0;
      shift_index = 1'b0;
      shift_dir   = 1'b0;
      s_arith     = 1'b0;
      if (op == OP_RTYPE) begin
         case (funct)
            FN_SUB: alu_op = ALU_SUB;
            FN_AND: alu_op = ALU_AND;
            FN_OR:  alu_op = ALU_OR;
            FN_SLT: alu_op = ALU_SLT;
            // shifter result enters on ALU port A, ALU op stays ADD
            FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV: begin
               alu_asrc    = 1'b1;
               shift_index = funct inside {FN_SLLV, FN_SRLV, FN_SRAV};
               shift_dir   = funct inside {FN_SRL, FN_SRA, FN_SRLV, FN_SRAV};
               s_arith     = funct inside {FN_SRA, FN_SRAV};
            end
            default: alu_op = ALU_ADD;
         endcase
      end else begin
         case (op)
            OP_ORI:  alu_op = ALU_OR;
            OP_LUI:  alu_op = ALU_LUI;
            default: alu_op = ALU_ADD;
         endcase
      end
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS sequencer: drives datapath enables/selects per state and
// times out memory accesses that never complete.
//
// state    | meaning
// S_FETCH  | read instruction; on ready latch IR and PC <- PC+4
// S_DECODE | one cycle, pick path from op/funct
// S_EXEC_R | R-type ALU/shift
// S_EXEC_I | addi/ori/lui with immediate
// S_ADDR   | lw/sw address = rs + sext(imm)
// S_MEM_RD | lw data read, wait for ready
// S_MEM_WR | sw data write, wait for ready
// S_WB_ALU | write ALU result
// S_WB_MEM | write loaded data
// S_BRANCH | compare, conditional PC update
// S_JUMP   | j/jal/jr PC update
// S_ERR    | illegal opcode or memory timeout, held until reset
import mips_defs::*;

module multicycle_ctrl #(
   parameter int         MAX_WAIT    = 15,
   parameter logic [3:0] RESET_STATE = 4'd0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       ir_write,
   output logic       reg_write,
   output logic [1:0] reg_dst,
   output logic [1:0] mem_to_reg,
   output logic       mem_read,
   output logic       mem_write,
   output logic       alu_src,
   output logic       alu_asrc,
   output logic [3:0] alu_op,
   output logic       ext_op,
   output logic [1:0] npc_op,
   output logic       shift_index,
   output logic       shift_dir,
   output logic       s_arith,
   output logic       error,
   output logic [3:0] state_o
);

   localparam int WCW = $clog2(MAX_WAIT + 1);

   state_t         state_q, state_d;
   logic [WCW-1:0] wait_q, wait_d;
   logic           error_q, error_d;

   logic       waiting, wait_tc, is_rtype, br_taken;
   logic       pc_write_c, ir_write_c, reg_write_c, mem_write_c;
   logic [3:0] dec_alu_op;
   logic       dec_asrc, dec_sidx, dec_sdir, dec_sar;

   alu_decode u_alu_decode (
      .op          (op),
      .funct       (funct),
      .alu_op      (dec_alu_op),
      .alu_asrc    (dec_asrc),
      .shift_index (dec_sidx),
      .shift_dir   (dec_sdir),
      .s_arith     (dec_sar)
   );

   assign is_rtype = (op == OP_RTYPE);
   assign br_taken = ((op == OP_BEQ) & zero) | ((op == OP_BNE) & ~zero);
   assign waiting  = (state_q inside {S_FETCH, S_MEM_RD, S_MEM_WR}) & ~mem_ready;
   assign wait_tc  = (wait_q == WCW'(MAX_WAIT - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= state_t'(RESET_STATE);
         wait_q  <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         error_q <= error_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH: begin
            if (mem_ready)    state_d = S_DECODE;
            else if (wait_tc) state_d = S_ERR;
         end
         S_DECODE: state_d = decode_next(op, funct);
         S_EXEC_R: state_d = S_WB_ALU;
         S_EXEC_I: state_d = S_WB_ALU;
         S_WB_ALU: state_d = S_FETCH;
         S_ADDR:   state_d = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD: begin
            if (mem_ready)    state_d = S_WB_MEM;
            else if (wait_tc) state_d = S_ERR;
         end
         S_MEM_WR: begin
            if (mem_ready)    state_d = S_FETCH;
            else if (wait_tc) state_d = S_ERR;
         end
         S_WB_MEM: state_d = S_FETCH;
         S_BRANCH: state_d = S_FETCH;
         S_JUMP:   state_d = S_FETCH;
         S_ERR:    state_d = S_ERR;
         default:  state_d = S_ERR;
      endcase
      wait_d  = (state_d != state_q) ? '0 : (waiting ? wait_q + 1'b1 : wait_q);
      error_d = error_q | (state_d == S_ERR);
   end

   always_comb begin
      pc_write_c  = 1'b0;
      ir_write_c  = 1'b0;
      reg_write_c = 1'b0;
      mem_write_c = 1'b0;
      mem_read    = 1'b0;
      reg_dst     = RD_RT;
      mem_to_reg  = M2R_ALU;
      alu_src     = 1'b0;
      alu_asrc    = 1'b0;
      alu_op      = ALU_ADD;
      ext_op      = 1'b0;
      npc_op      = NPC_PC4;
      shift_index = 1'b0;
      shift_dir   = 1'b0;
      s_arith     = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_read = 1'b1;
            if (mem_ready) begin
               ir_write_c = 1'b1;
               pc_write_c = 1'b1;
            end
         end
         S_EXEC_R, S_EXEC_I, S_WB_ALU: begin
            alu_op      = dec_alu_op;
            alu_asrc    = dec_asrc;
            shift_index = dec_sidx;
            shift_dir   = dec_sdir;
            s_arith     = dec_sar;
            alu_src     = ~is_rtype;
            ext_op      = (op == OP_ADDI);
            if (state_q == S_WB_ALU) begin
               reg_write_c = 1'b1;
               reg_dst     = is_rtype ? RD_RD : RD_RT;
            end
         end
         // address stays on the bus for the whole memory access
         S_ADDR, S_MEM_RD, S_MEM_WR: begin
            alu_src     = 1'b1;
            ext_op      = 1'b1;
            alu_op      = ALU_ADD;
            mem_read    = (state_q == S_MEM_RD);
            mem_write_c = (state_q == S_MEM_WR);
         end
         S_WB_MEM: begin
            reg_write_c = 1'b1;
            mem_to_reg  = M2R_DM;
         end
         S_BRANCH: begin
            alu_op = ALU_SUB;
            if (br_taken) begin
               pc_write_c = 1'b1;
               npc_op     = NPC_BRANCH;
            end
         end
         S_JUMP: begin
            pc_write_c = 1'b1;
            npc_op     = (is_rtype && funct == FN_JR) ? NPC_JR : NPC_JUMP;
            if (op == OP_JAL) begin
               reg_write_c = 1'b1;
               reg_dst     = RD_RA;
               mem_to_reg  = M2R_PC4;
            end
         end
         default: ;
      endcase
   end

   // write strobes are masked while reset is held, even in S_FETCH with ready
   assign pc_write  = pc_write_c & rst;
   assign ir_write  = ir_write_c & rst;
   assign reg_write = reg_write_c & rst;
   assign mem_write = mem_write_c & rst;
   assign error     = error_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scenario bench for multicycle_ctrl with a per-instruction reference model
// (latency, strobe counts and write-back selects) for random instruction mixes.
module tb_multicycle_ctrl;

   localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3,
                          A_SLT = 4'd4, A_LUI = 4'd5;

   localparam logic [11:0] INSTR_TBL [21] = '{
      {6'h00, 6'h20}, {6'h00, 6'h22}, {6'h00, 6'h24}, {6'h00, 6'h25},
      {6'h00, 6'h2A}, {6'h00, 6'h00}, {6'h00, 6'h02}, {6'h00, 6'h03},
      {6'h00, 6'h04}, {6'h00, 6'h06}, {6'h00, 6'h07}, {6'h00, 6'h08},
      {6'h08, 6'h00}, {6'h0D, 6'h00}, {6'h0F, 6'h00}, {6'h23, 6'h00},
      {6'h2B, 6'h00}, {6'h04, 6'h00}, {6'h05, 6'h00}, {6'h02, 6'h00},
      {6'h03, 6'h00}
   };

   logic clk = 1'b0, rst = 1'b0;
   logic [5:0] op = '0, funct = '0;
   logic zero = 1'b0, mem_ready = 1'b0;

   logic pc_write, ir_write, reg_write, mem_read, mem_write, alu_src, alu_asrc;
   logic ext_op, shift_index, shift_dir, s_arith, error;
   logic [1:0] reg_dst, mem_to_reg, npc_op;
   logic [3:0] alu_op, state_o;
   logic [20:0] all_out;

   int n_pass = 0, n_total = 0;

   logic [31:0] pcw_v, irw_v, rw_v, mr_v, mw_v;
   logic [1:0]  npc_last, rw_dst, rw_m2r;
   logic [3:0]  rw_alu, end_state;
   logic        rw_asrc, rw_sidx, rw_sdir, rw_sar, rw_bsrc, rw_ext;
   logic        fetch_npc_bad, err_seen;

   multicycle_ctrl #(.MAX_WAIT(15), .RESET_STATE(4'd0)) dut (
      .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
      .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .mem_read(mem_read), .mem_write(mem_write), .alu_src(alu_src),
      .alu_asrc(alu_asrc), .alu_op(alu_op), .ext_op(ext_op), .npc_op(npc_op),
      .shift_index(shift_index), .shift_dir(shift_dir), .s_arith(s_arith),
      .error(error), .state_o(state_o)
   );

   assign all_out = {pc_write, ir_write, reg_write, reg_dst, mem_to_reg, mem_read,
                     mem_write, alu_src, alu_asrc, alu_op, ext_op, npc_op,
                     shift_index, shift_dir, s_arith};

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Drives one instruction for ncyc cycles (fetch waits fw, memory waits mw)
   // and records what the controller did; checks live in the callers.
   task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                            input int fw, input int mw, input int ncyc);
      logic is_mem;
      is_mem = (o == 6'h23) || (o == 6'h2B);
      pcw_v = '0; irw_v = '0; rw_v = '0; mr_v = '0; mw_v = '0;
      npc_last = '0; rw_dst = '0; rw_m2r = '0; rw_alu = '0;
      {rw_asrc, rw_sidx, rw_sdir, rw_sar, rw_bsrc, rw_ext} = '0;
      fetch_npc_bad = 1'b0; err_seen = 1'b0;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         op = o; funct = f; zero = z;
         if (c < fw)                                        mem_ready = 1'b0;
         else if (c == fw)                                  mem_ready = 1'b1;
         else if (is_mem && c >= fw + 3 && c < fw + 3 + mw) mem_ready = 1'b0;
         else if (is_mem && c == fw + 3 + mw)               mem_ready = 1'b1;
         else                                               mem_ready = 1'($urandom_range(0, 1));
         #1;
         pcw_v[c] = pc_write; irw_v[c] = ir_write; rw_v[c] = reg_write;
         mr_v[c] = mem_read;  mw_v[c] = mem_write;
         if (ir_write && npc_op != 2'd0) fetch_npc_bad = 1'b1;
         if (pc_write && !ir_write) npc_last = npc_op;
         if (reg_write) begin
            rw_dst = reg_dst; rw_m2r = mem_to_reg; rw_alu = alu_op;
            {rw_asrc, rw_sidx, rw_sdir, rw_sar, rw_bsrc, rw_ext} =
               {alu_asrc, shift_index, shift_dir, s_arith, alu_src, ext_op};
         end
         if (error) err_seen = 1'b1;
      end
      @(posedge clk);
      #1;
      end_state = state_o;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0; mem_ready = 1'b0;
      #1;
      rst = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b0; mem_ready = 1'b0;
      #1;
      n_total++;
      if ({error, state_o} !== 5'd0) $display("FAIL reset_state got err=%b st=%0d want 0/0", error, state_o);
      else n_pass++;
      n_total++;
      if (all_out !== {3'b000, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 2'd0, 3'b000})
         $display("FAIL reset_outputs got %h want only mem_read", all_out);
      else n_pass++;
      mem_ready = 1'b1;
      #1;
      n_total++;
      if ({pc_write, ir_write, reg_write, mem_write} !== 4'b0000)
         $display("FAIL reset_no_strobe got %b want 0000", {pc_write, ir_write, reg_write, mem_write});
      else n_pass++;
      #1;
      rst = 1'b1; mem_ready = 1'b0;
   endtask

   task automatic test_add();
      run_instr(6'h00, 6'h20, 1'b0, 0, 0, 4);
      n_total++;
      if ({pcw_v[3:0], irw_v[3:0], rw_v[3:0]} !== {4'b0001, 4'b0001, 4'b1000})
         $display("FAIL add_strobes got pc=%b ir=%b rw=%b want 0001 0001 1000", pcw_v[3:0], irw_v[3:0], rw_v[3:0]);
      else n_pass++;
      n_total++;
      if ({rw_dst, rw_m2r, rw_alu, fetch_npc_bad} !== {2'd1, 2'd0, A_ADD, 1'b0})
         $display("FAIL add_wb got dst=%0d m2r=%0d alu=%0d npcbad=%b want 1 0 %0d 0", rw_dst, rw_m2r, rw_alu, fetch_npc_bad, A_ADD);
      else n_pass++;
      n_total++;
      if (end_state !== 4'd0) $display("FAIL add_latency got state %0d want 0 after 4 cycles", end_state);
      else n_pass++;
   endtask

   task automatic test_lw_wait();
      run_instr(6'h23, 6'h00, 1'b0, 0, 3, 8);
      n_total++;
      if (mr_v[7:0] !== 8'b0111_1001) $display("FAIL lw_mem_read got %b want 01111001", mr_v[7:0]);
      else n_pass++;
      n_total++;
      if ({rw_v[7:0], rw_m2r, rw_dst} !== {8'b1000_0000, 2'd1, 2'd0})
         $display("FAIL lw_wb got rw=%b m2r=%0d dst=%0d want 10000000 1 0", rw_v[7:0], rw_m2r, rw_dst);
      else n_pass++;
      n_total++;
      if ({end_state, mw_v} !== 36'd0) $display("FAIL lw_end got state=%0d mw=%h want 0 0", end_state, mw_v);
      else n_pass++;
   endtask

   task automatic test_branch();
      run_instr(6'h04, 6'h00, 1'b1, 0, 0, 3);
      n_total++;
      if ({pcw_v[2:0], npc_last, end_state} !== {3'b101, 2'd1, 4'd0})
         $display("FAIL beq_taken got pc=%b npc=%0d st=%0d want 101 1 0", pcw_v[2:0], npc_last, end_state);
      else n_pass++;
      run_instr(6'h04, 6'h00, 1'b0, 0, 0, 3);
      n_total++;
      if ({pcw_v[2:0], end_state} !== {3'b001, 4'd0})
         $display("FAIL beq_not_taken got pc=%b st=%0d want 001 0", pcw_v[2:0], end_state);
      else n_pass++;
   endtask

   task automatic test_jal();
      run_instr(6'h03, 6'h00, 1'b0, 0, 0, 3);
      n_total++;
      if ({pcw_v[2:0], npc_last, rw_v[2:0], rw_dst, rw_m2r} !== {3'b101, 2'd2, 3'b100, 2'd2, 2'd2})
         $display("FAIL jal got pc=%b npc=%0d rw=%b dst=%0d m2r=%0d want 101 2 100 2 2",
                  pcw_v[2:0], npc_last, rw_v[2:0], rw_dst, rw_m2r);
      else n_pass++;
   endtask

   task automatic test_reset_mem_wr();
      run_instr(6'h2B, 6'h00, 1'b0, 0, 5, 4);
      n_total++;
      if ({mw_v[3:0], mem_write} !== 5'b1000_1) $display("FAIL sw_mem_write got %b,%b want 1000,1", mw_v[3:0], mem_write);
      else n_pass++;
      rst = 1'b0;
      #1;
      n_total++;
      if ({mem_write, state_o} !== 5'd0) $display("FAIL rst_in_mem_wr got mw=%b st=%0d want 0 0", mem_write, state_o);
      else n_pass++;
      @(negedge clk);
      rst = 1'b1; mem_ready = 1'b0;
   endtask

   task automatic test_illegal();
      run_instr(6'h3F, 6'h00, 1'b0, 0, 0, 2);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         mem_ready = 1'($urandom_range(0, 1));
         #1;
         n_total++;
         if ({error, pc_write, ir_write, reg_write, mem_write, mem_read} !== 6'b100000)
            $display("FAIL illegal_err[%0d] got %b want 100000", k,
                     {error, pc_write, ir_write, reg_write, mem_write, mem_read});
         else n_pass++;
      end
      #1;
      rst = 1'b0;
      #1;
      n_total++;
      if ({error, state_o} !== 5'd0) $display("FAIL illegal_reset got err=%b st=%0d want 0 0", error, state_o);
      else n_pass++;
      #1;
      rst = 1'b1; mem_ready = 1'b0;
   endtask

   task automatic test_timeout();
      logic early_err;
      early_err = 1'b0;
      @(negedge clk);
      rst = 1'b0; mem_ready = 1'b0;
      #1;
      rst = 1'b1;
      #1;
      for (int k = 0; k < 16; k++) begin
         if (k > 0) begin
            @(negedge clk);
            #1;
         end
         if (k < 15 && (error || state_o != 4'd0)) early_err = 1'b1;
      end
      n_total++;
      if (early_err !== 1'b0) $display("FAIL timeout_early got early error/leave want none in 15 cycles");
      else n_pass++;
      n_total++;
      if ({error, mem_read} !== 2'b10) $display("FAIL timeout_err got err=%b mr=%b want 1 0", error, mem_read);
      else n_pass++;
      do_reset();
      #1;
      n_total++;
      if (error !== 1'b0) $display("FAIL timeout_clear got err=%b want 0", error);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [5:0] o, f;
      logic z, is_r, is_i, is_lw, is_sw, is_br, is_j, is_jr, is_jal, taken;
      int fw, mw, len, e_pc, e_rw, e_mw, e_mr;
      logic [1:0] e_npc, e_dst, e_m2r;
      logic [3:0] e_alu;
      logic [5:0] e_ctl;
      for (int it = 0; it < 40; it++) begin
         {o, f} = INSTR_TBL[$urandom_range(0, 20)];
         z  = 1'($urandom_range(0, 1));
         fw = int'($urandom_range(0, 4));
         mw = int'($urandom_range(0, 4));
         is_jr  = (o == 6'h00) && (f == 6'h08);
         is_r   = (o == 6'h00) && !is_jr;
         is_i   = o inside {6'h08, 6'h0D, 6'h0F};
         is_lw  = (o == 6'h23);
         is_sw  = (o == 6'h2B);
         is_br  = o inside {6'h04, 6'h05};
         is_jal = (o == 6'h03);
         is_j   = (o inside {6'h02, 6'h03}) || is_jr;
         taken  = ((o == 6'h04) && z) || ((o == 6'h05) && !z);
         if (!(is_lw || is_sw)) mw = 0;
         len   = fw + ((is_r || is_i) ? 4 : is_lw ? 5 + mw : is_sw ? 4 + mw : 3);
         e_pc  = 1 + ((is_j || (is_br && taken)) ? 1 : 0);
         e_npc = is_jr ? 2'd3 : is_j ? 2'd2 : 2'd1;
         e_rw  = (is_r || is_i || is_lw || is_jal) ? 1 : 0;
         e_dst = is_r ? 2'd1 : is_jal ? 2'd2 : 2'd0;
         e_m2r = is_lw ? 2'd1 : is_jal ? 2'd2 : 2'd0;
         e_mw  = is_sw ? mw + 1 : 0;
         e_mr  = fw + 1 + (is_lw ? mw + 1 : 0);
         if (is_r) begin
            case (f)
               6'h22:   e_alu = A_SUB;
               6'h24:   e_alu = A_AND;
               6'h25:   e_alu = A_OR;
               6'h2A:   e_alu = A_SLT;
               default: e_alu = A_ADD;
            endcase
         end else begin
            e_alu = (o == 6'h0D) ? A_OR : (o == 6'h0F) ? A_LUI : A_ADD;
         end
         e_ctl = {is_r && (f inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07}),
                  is_r && (f inside {6'h04, 6'h06, 6'h07}),
                  is_r && (f inside {6'h02, 6'h03, 6'h06, 6'h07}),
                  is_r && (f inside {6'h03, 6'h07}),
                  is_i, o == 6'h08};

         run_instr(o, f, z, fw, mw, len);

         n_total++;
         if ({end_state, $countones(irw_v) == 1, err_seen, fetch_npc_bad} !== {4'd0, 1'b1, 1'b0, 1'b0})
            $display("FAIL rand[%0d] op=%h fn=%h end got st=%0d ir=%0d err=%b npcbad=%b want 0 1 0 0",
                     it, o, f, end_state, $countones(irw_v), err_seen, fetch_npc_bad);
         else n_pass++;
         n_total++;
         if ($countones(pcw_v) != e_pc || $countones(rw_v) != e_rw ||
             $countones(mw_v) != e_mw || $countones(mr_v) != e_mr)
            $display("FAIL rand[%0d] op=%h fn=%h counts got pc%0d rw%0d mw%0d mr%0d want pc%0d rw%0d mw%0d mr%0d",
                     it, o, f, $countones(pcw_v), $countones(rw_v), $countones(mw_v), $countones(mr_v),
                     e_pc, e_rw, e_mw, e_mr);
         else n_pass++;
         if (e_pc == 2) begin
            n_total++;
            if (npc_last !== e_npc) $display("FAIL rand[%0d] op=%h fn=%h npc got %0d want %0d", it, o, f, npc_last, e_npc);
            else n_pass++;
         end
         if (e_rw == 1) begin
            n_total++;
            if ({rw_dst, rw_m2r} !== {e_dst, e_m2r})
               $display("FAIL rand[%0d] op=%h fn=%h wb got dst%0d m2r%0d want dst%0d m2r%0d",
                        it, o, f, rw_dst, rw_m2r, e_dst, e_m2r);
            else n_pass++;
         end
         if (is_r || is_i) begin
            n_total++;
            if ({rw_alu, rw_asrc, rw_sidx, rw_sdir, rw_sar, rw_bsrc, rw_ext} !== {e_alu, e_ctl})
               $display("FAIL rand[%0d] op=%h fn=%h alu got %h want %h", it, o, f,
                        {rw_alu, rw_asrc, rw_sidx, rw_sdir, rw_sar, rw_bsrc, rw_ext}, {e_alu, e_ctl});
            else n_pass++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_lw_wait();
      test_branch();
      test_jal();
      test_reset_mem_wr();
      test_random();
      test_illegal();
      test_timeout();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
